// File: rtl/rs232_pkg.sv
// Shared constants for the RS232 transmit arbiter: byte width and the
// 2-bit state encoding of the packet-lock FSM.
package rs232_pkg;

    localparam int BYTE_W = 8;

    // Packet-lock FSM states (plain constants so older code can reuse them)
    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select. The search starts at ptr+1 and
// wraps, so the previous winner (ptr) has the lowest priority this round.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] winner_idx,
    output logic          any
);

    logic [PW-1:0] idx_s;

    // Walk the requesters in priority order; the first one found wins
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx_s      = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = PW'((int'(ptr) + k) % N);
            if (!any && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                winner_idx    = idx_s;
                any           = 1'b1;
            end else begin
                // keep the earlier, higher-priority winner
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Shares one RS232 byte transmitter between NUM_REQ requesters with
// round-robin arbitration at packet granularity: an owner keeps the
// transmitter until it sends a byte flagged Last.
// Optional build macro RS232_TX_ARB_TIMEOUT_EN: releases a stalled lock after
// TIMEOUT_CYCLES cycles in LOAD without a request and pulses Abort.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int TIMEOUT_BITS   = 22
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [BYTE_W*NUM_REQ-1:0] ReqData,
    input  logic [NUM_REQ-1:0]        ReqLast,
    output logic [NUM_REQ-1:0]        Ack,
    output logic [NUM_REQ-1:0]        Grant,
    output logic [BYTE_W-1:0]         TxData,
    output logic                      Send,
    input  logic                      Busy,
    output logic                      Abort
);

    localparam int PW = $clog2(NUM_REQ);

    // Reject parameter sets the counter or the picker cannot represent
    if (NUM_REQ < 2 || NUM_REQ > 8 ||
        (64'd1 << TIMEOUT_BITS) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("rs232_tx_arbiter: unsupported NUM_REQ/TIMEOUT parameters");
    end

    logic [1:0]         state_r;
    logic [PW-1:0]      rr_ptr_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] ack_r;
    logic [BYTE_W-1:0]  tx_data_r;
    logic               send_r;
    logic               last_r;

    logic [NUM_REQ-1:0] pick_winner_s;
    logic [PW-1:0]      pick_idx_s;
    logic               pick_any_s;

    logic               req_g_s;
    logic               last_g_s;
    logic [BYTE_W-1:0]  data_g_s;
    logic               capture_s;
    logic               expire_s;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .req        (Req),
        .ptr        (rr_ptr_r),
        .winner     (pick_winner_s),
        .winner_idx (pick_idx_s),
        .any        (pick_any_s)
    );

    // Select the owner's request, Last flag and byte using the one-hot grant
    always_comb begin
        req_g_s  = |(Req & grant_r);
        last_g_s = |(ReqLast & grant_r);
        data_g_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_g_s = data_g_s | (ReqData[i*BYTE_W +: BYTE_W] & {BYTE_W{grant_r[i]}});
        end
    end

    // A byte is taken only when the transmitter is idle and the owner is offering
    assign capture_s = (state_r == LOAD) && !Busy && req_g_s;

`ifdef RS232_TX_ARB_TIMEOUT_EN
    logic                    stall_s;
    logic [TIMEOUT_BITS-1:0] stall_cnt_r;
    logic                    abort_r;

    assign stall_s  = (state_r == LOAD) && !req_g_s;
    assign expire_s = stall_s && (stall_cnt_r == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

    // Count stalled LOAD cycles; any capture or leaving LOAD restarts the count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r <= '0;
            abort_r     <= 1'b0;
        end else begin
            abort_r <= expire_s;
            if (state_r != LOAD || capture_s || expire_s) begin
                stall_cnt_r <= '0;
            end else if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + TIMEOUT_BITS'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign Abort = abort_r;
`else
    assign expire_s = 1'b0;
    assign Abort    = 1'b0;
`endif

    // Packet-lock FSM driving the transmitter Send/Busy handshake
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= ARB;
            rr_ptr_r  <= PW'(NUM_REQ - 1);
            grant_r   <= '0;
            ack_r     <= '0;
            tx_data_r <= '0;
            send_r    <= 1'b0;
            last_r    <= 1'b0;
        end else begin
            ack_r <= '0;
            case (state_r)
                ARB: begin
                    if (pick_any_s) begin
                        grant_r  <= pick_winner_s;
                        rr_ptr_r <= pick_idx_s;
                        state_r  <= LOAD;
                    end else begin
                        state_r  <= ARB;
                    end
                end
                LOAD: begin
                    if (expire_s) begin
                        // rr_ptr_r still names the stalled owner: lowest priority next
                        grant_r <= '0;
                        state_r <= ARB;
                    end else if (capture_s) begin
                        tx_data_r <= data_g_s;
                        last_r    <= last_g_s;
                        ack_r     <= grant_r;
                        send_r    <= 1'b1;
                        state_r   <= SEND;
                    end else begin
                        state_r   <= LOAD;
                    end
                end
                SEND: begin
                    if (Busy) begin
                        send_r  <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        state_r <= SEND;
                    end
                end
                DRAIN: begin
                    if (!Busy) begin
                        if (last_r) begin
                            grant_r <= '0;
                            state_r <= ARB;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    grant_r <= '0;
                    send_r  <= 1'b0;
                    state_r <= ARB;
                end
            endcase
        end
    end

    assign Ack    = ack_r;
    assign Grant  = grant_r;
    assign TxData = tx_data_r;
    assign Send   = send_r;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter: directed scenarios followed by
// randomized packet traffic checked against a round-robin packet model.
module tb_rs232_tx_arbiter;

    localparam int NR    = 4;
    localparam int TO    = 100;
    localparam int FRAME = 10;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [NR-1:0]   Req;
    logic [8*NR-1:0] ReqData;
    logic [NR-1:0]   ReqLast;
    logic [NR-1:0]   Ack;
    logic [NR-1:0]   Grant;
    logic [7:0]      TxData;
    logic            Send;
    logic            Busy;
    logic            Abort;

    logic            req_a  [NR];
    logic [7:0]      data_a [NR];
    logic            last_a [NR];
    logic            force_busy;
    bit              gap_en;

    int              checks = 0;
    int              failures = 0;
    int              drv_timeouts = 0;
    int              busy_cnt = 0;
    int              send_busy_err = 0;
    int              onehot_err = 0;
    int              abort_cnt = 0;
    logic [NR-1:0]   grant_prev = '0;
    logic            send_prev = 1'b0;

    logic [7:0]      tx_log[$];
    int              grant_log[$];
    int              ack_log[$];
    byte_t           stim_q [NR][$];
    byte_t           model_q [NR][$];
    logic [7:0]      exp_tx[$];
    int              exp_own[$];

    rs232_tx_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_BITS   (22)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .ReqData (ReqData),
        .ReqLast (ReqLast),
        .Ack     (Ack),
        .Grant   (Grant),
        .TxData  (TxData),
        .Send    (Send),
        .Busy    (Busy),
        .Abort   (Abort)
    );

    always #5 Clk = ~Clk;

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign Req[gi]             = req_a[gi];
        assign ReqData[gi*8 +: 8]  = data_a[gi];
        assign ReqLast[gi]         = last_a[gi];
    end

    // Transmitter model: accepts Send when idle, then stays busy for one frame
    always @(posedge Clk) begin
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (Send && !Busy) begin
            busy_cnt <= FRAME;
            tx_log.push_back(TxData);
        end
    end
    assign Busy = force_busy || (busy_cnt > 0);

    // Observers: grant hand-overs, Ack pulses, Abort pulses, protocol errors
    always @(negedge Clk) begin
        if (Grant != '0 && Grant != grant_prev) begin
            for (int i = 0; i < NR; i++) if (Grant[i]) grant_log.push_back(i);
        end
        grant_prev <= Grant;
        if ($countones(Grant) > 1) onehot_err <= onehot_err + 1;
        if (Send && !send_prev && Busy) send_busy_err <= send_busy_err + 1;
        send_prev <= Send;
        for (int i = 0; i < NR; i++) if (Ack[i]) ack_log.push_back(i);
        if (Abort) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int g_at(input int k);
        if (k < grant_log.size()) return grant_log[k];
        else return -1;
    endfunction

    function automatic logic [31:0] t_at(input int k);
        if (k < tx_log.size()) return {24'd0, tx_log[k]};
        else return 32'hffff_ffff;
    endfunction

    task automatic wait_ack(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge Clk); #1;
            if (Ack[i]) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge Clk); #1;
            if (Grant == '0 && !Busy && !Send) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i] = 1'b0; data_a[i] = 8'h00; last_a[i] = 1'b0;
        end
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        tx_log.delete(); grant_log.delete(); ack_log.delete();
    endtask

    // One requester: offer each queued byte, hold until Ack, move on a cycle later
    task automatic drive(input int i);
        byte_t b;
        bit    ok;
        bit    mid = 1'b0;
        while (stim_q[i].size() > 0) begin
            b = stim_q[i].pop_front();
            if (mid && gap_en) begin
                req_a[i] = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge Clk);
                #1;
            end
            req_a[i] = 1'b1; data_a[i] = b.d; last_a[i] = b.l;
            wait_ack(i, 5000, ok);
            if (!ok) begin
                drv_timeouts++;
                break;
            end
            @(posedge Clk); #1;
            mid = !b.l;
        end
        req_a[i] = 1'b0;
    endtask

    task automatic add_pkt(input int i, input int nbytes);
        for (int k = 0; k < nbytes; k++)
            stim_q[i].push_back('{d: 8'($urandom_range(0, 255)), l: (k == nbytes - 1)});
    endtask

    // Reference: whole packets go out in round-robin order from the reset pointer
    task automatic build_expected();
        int    ptr = NR - 1;
        int    w;
        byte_t b;
        exp_tx.delete(); exp_own.delete();
        for (int guard = 0; guard < 1000; guard++) begin
            w = -1;
            for (int k = 1; k <= NR; k++)
                if (w < 0 && model_q[(ptr + k) % NR].size() > 0) w = (ptr + k) % NR;
            if (w < 0) break;
            exp_own.push_back(w);
            do begin
                b = model_q[w].pop_front();
                exp_tx.push_back(b.d);
            end while (!b.l && model_q[w].size() > 0);
            ptr = w;
        end
    endtask

    initial begin
        bit ok;
        int sent_early;
        int lat;
        int n3;
        logic [7:0] lock_bytes [4];
        lock_bytes[0] = 8'h01; lock_bytes[1] = 8'h02; lock_bytes[2] = 8'h03; lock_bytes[3] = 8'hA2;

        force_busy = 1'b0;
        gap_en     = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_a[i] = 1'b0; data_a[i] = 8'h00; last_a[i] = 1'b0;
        end
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ack",    32'(Ack),    32'h0);
        check("rst_grant",  32'(Grant),  32'h0);
        check("rst_txdata", 32'(TxData), 32'h0);
        check("rst_send",   32'(Send),   32'h0);
        check("rst_abort",  32'(Abort),  32'h0);
        Reset = 1'b0;
        tx_log.delete(); grant_log.delete(); ack_log.delete();

        // Single one-byte packet from requester 0
        req_a[0] = 1'b1; data_a[0] = 8'h55; last_a[0] = 1'b1;
        wait_ack(0, 200, ok);
        check("t1_ack_seen", 32'(ok), 32'h1);
        check("t1_send_with_ack", 32'(Send), 32'h1);
        check("t1_txdata", 32'(TxData), 32'h55);
        check("t1_grant", 32'(Grant), 32'h1);
        @(posedge Clk); #1;
        req_a[0] = 1'b0;
        wait_idle(200, ok);
        check("t1_idle", 32'(ok), 32'h1);
        check("t1_tx_count", 32'(tx_log.size()), 32'd1);
        check("t1_tx_byte", t_at(0), 32'h55);
        check("t1_ack_count", 32'(ack_log.size()), 32'd1);

        // Packet lock: requester 1 sends three bytes while requester 2 waits
        do_reset();
        stim_q[1].push_back('{d: 8'h01, l: 1'b0});
        stim_q[1].push_back('{d: 8'h02, l: 1'b0});
        stim_q[1].push_back('{d: 8'h03, l: 1'b1});
        stim_q[2].push_back('{d: 8'hA2, l: 1'b1});
        fork drive(1); drive(2); join
        wait_idle(500, ok);
        check("t2_idle", 32'(ok), 32'h1);
        check("t2_tx_count", 32'(tx_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t2_byte%0d", k), t_at(k), 32'(lock_bytes[k]));
        check("t2_owner0", 32'(g_at(0)), 32'd1);
        check("t2_owner1", 32'(g_at(1)), 32'd2);
        check("t2_grants", 32'(grant_log.size()), 32'd2);

        // Round-robin with all four requesting one-byte packets
        do_reset();
        stim_q[0].push_back('{d: 8'hB0, l: 1'b1});
        stim_q[0].push_back('{d: 8'hB4, l: 1'b1});
        stim_q[1].push_back('{d: 8'hB1, l: 1'b1});
        stim_q[2].push_back('{d: 8'hB2, l: 1'b1});
        stim_q[3].push_back('{d: 8'hB3, l: 1'b1});
        fork drive(0); drive(1); drive(2); drive(3); join
        wait_idle(500, ok);
        check("t3_idle", 32'(ok), 32'h1);
        for (int k = 0; k < 5; k++) check($sformatf("t3_owner%0d", k), 32'(g_at(k)), 32'(k % 4));
        check("t3_last_byte", t_at(4), 32'hB4);

        // Transmitter busy across reset release
        force_busy = 1'b1;
        do_reset();
        req_a[3] = 1'b1; data_a[3] = 8'h3C; last_a[3] = 1'b1;
        sent_early = 0;
        repeat (50) begin
            @(posedge Clk); #1;
            if (Send) sent_early++;
        end
        check("t4_no_send_while_busy", 32'(sent_early), 32'd0);
        check("t4_grant_held", 32'(Grant), 32'h8);
        check("t4_no_early_ack", 32'(ack_log.size()), 32'd0);
        force_busy = 1'b0;
        wait_ack(3, 50, ok);
        check("t4_ack_seen", 32'(ok), 32'h1);
        check("t4_send_with_ack", 32'(Send), 32'h1);
        check("t4_txdata", 32'(TxData), 32'h3C);
        @(posedge Clk); #1;
        req_a[3] = 1'b0;
        wait_idle(200, ok);
        check("t4_idle", 32'(ok), 32'h1);

        // Reset while the arbiter is in SEND
        do_reset();
        req_a[0] = 1'b1; data_a[0] = 8'h5A; last_a[0] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge Clk); #1;
            if (Send) ok = 1'b1;
        end
        check("t5_send_seen", 32'(ok), 32'h1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("t5_send_dropped", 32'(Send), 32'h0);
        check("t5_grant_cleared", 32'(Grant), 32'h0);
        check("t5_ack_cleared", 32'(Ack), 32'h0);
        req_a[0] = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        tx_log.delete(); grant_log.delete(); ack_log.delete();
        stim_q[0].push_back('{d: 8'h77, l: 1'b1});
        stim_q[1].push_back('{d: 8'h11, l: 1'b1});
        fork drive(0); drive(1); join
        wait_idle(500, ok);
        check("t5_restart_owner0", 32'(g_at(0)), 32'd0);
        check("t5_restart_owner1", 32'(g_at(1)), 32'd1);
        check("t5_ack_count", 32'(ack_log.size()), 32'd2);

        // Owner 2 stalls mid-packet while requester 3 waits
        do_reset();
        req_a[2] = 1'b1; data_a[2] = 8'hC2; last_a[2] = 1'b0;
        wait_ack(2, 100, ok);
        check("t6_ack2", 32'(ok), 32'h1);
        @(posedge Clk); #1;
        req_a[2] = 1'b0;
        req_a[3] = 1'b1; data_a[3] = 8'hC3; last_a[3] = 1'b1;
`ifdef RS232_TX_ARB_TIMEOUT_EN
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (!Busy) ok = 1'b1;
            else begin @(posedge Clk); #1; end
        end
        check("t6_busy_fell", 32'(ok), 32'h1);
        // one DRAIN cycle sees Busy low, then TO stalled LOAD cycles, then Abort
        lat = 0;
        ok  = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(posedge Clk); #1;
            lat++;
            if (Abort) ok = 1'b1;
        end
        check("t6_abort_seen", 32'(ok), 32'h1);
        check("t6_abort_latency", 32'(lat), 32'(TO + 1));
        check("t6_grant_released", 32'(Grant), 32'h0);
        wait_ack(3, 100, ok);
        check("t6_ack3", 32'(ok), 32'h1);
        check("t6_next_owner", 32'(g_at(1)), 32'd3);
        @(posedge Clk); #1;
        req_a[3] = 1'b0;
        wait_idle(200, ok);
`else
        repeat (300) @(posedge Clk);
        #1;
        check("t6_lock_held", 32'(Grant), 32'h4);
        check("t6_abort_low", 32'(Abort), 32'h0);
        n3 = 0;
        foreach (ack_log[k]) if (ack_log[k] == 3) n3++;
        check("t6_no_ack3", 32'(n3), 32'd0);
`endif

        // Randomized multi-packet traffic against the round-robin packet model
        gap_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                repeat ($urandom_range(0, 3)) add_pkt(i, $urandom_range(1, 4));
                model_q[i] = stim_q[i];
            end
            build_expected();
            fork drive(0); drive(1); drive(2); drive(3); join
            wait_idle(1000, ok);
            check($sformatf("rnd%0d_idle", r), 32'(ok), 32'h1);
            check($sformatf("rnd%0d_tx_count", r), 32'(tx_log.size()), 32'(exp_tx.size()));
            foreach (exp_tx[k]) check($sformatf("rnd%0d_byte%0d", r, k), t_at(k), 32'(exp_tx[k]));
            check($sformatf("rnd%0d_pkt_count", r), 32'(grant_log.size()), 32'(exp_own.size()));
            foreach (exp_own[k]) check($sformatf("rnd%0d_owner%0d", r, k), 32'(g_at(k)), 32'(exp_own[k]));
            check($sformatf("rnd%0d_acks", r), 32'(ack_log.size()), 32'(exp_tx.size()));
        end

        check("send_rise_while_busy", 32'(send_busy_err), 32'd0);
        check("grant_onehot", 32'(onehot_err), 32'd0);
        check("driver_ack_timeouts", 32'(drv_timeouts), 32'd0);
`ifdef RS232_TX_ARB_TIMEOUT_EN
        check("abort_pulses", 32'(abort_cnt), 32'd1);
`else
        check("abort_pulses", 32'(abort_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arbiter.md
Name: rs232_tx_arbiter

Overview:
- Shares one RS232 byte transmitter between NUM_REQ requesters.
- Round-robin arbitration at packet granularity: once granted, a requester keeps the transmitter until it sends a byte flagged Last.
- Drives the transmitter's Send/TxData handshake and observes its Busy.
- Sits between protocol/framing blocks and the single RS232 transmitter on the board UART pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4000000, lock-release timeout in Clk cycles (used only with the optional feature).
- TIMEOUT_BITS, 22, counter width; must satisfy 2^TIMEOUT_BITS > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  NUM_REQ  per-requester byte valid; held until the matching Ack.
- ReqData  in  8*NUM_REQ  flattened bytes; requester i occupies [8i+7:8i]; stable while Req[i] is high.
- ReqLast  in  NUM_REQ  marks the current byte as the final byte of the packet.
- Ack  out  NUM_REQ  one-cycle pulse when the byte is captured.
- Grant  out  NUM_REQ  one-hot packet ownership; all zero when unowned.
- TxData  out  8  byte to the transmitter.
- Send  out  1  transmit request to the transmitter.
- Busy  in  1  transmitter busy; low means ready to accept Send.
- Abort  out  1  one-cycle pulse on timeout release (tied 0 without the optional feature).

Behaviour:
- Reset values: Ack=0, Grant=0, TxData=0x00, Send=0, Abort=0, state=ARB, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- Transmitter handshake per byte: assert Send only while Busy=0; hold Send high until Busy=1; drop Send; the byte is complete when Busy returns to 0.
- ARB:
  - If Req is zero, stay in ARB.
  - Otherwise pick the first set Req searching upward from rr_ptr+1, with wrap-around.
  - Set Grant one-hot, set rr_ptr to the winner, go to LOAD.
  - Arbitration takes 1 cycle.
- LOAD:
  - Waits for Busy=0 and Req[g]=1, then in that cycle captures TxData=ReqData[g], captures last_q=ReqLast[g], pulses Ack[g], asserts Send, and goes to SEND.
  - Req[g] low in LOAD means a mid-packet stall: remain in LOAD with the lock held.
- SEND: hold Send=1 until Busy=1; then Send=0 and go to DRAIN.
- DRAIN:
  - Wait for Busy=0.
  - If last_q, clear Grant and go to ARB.
  - Otherwise go to LOAD with the same owner.
- Minimum overhead from Busy falling to the next Send is 1 cycle within a packet and 2 cycles between packets.
- Ack timing: exactly one Ack pulse per byte. The requester may change ReqData/ReqLast, or drop Req, the cycle after Ack.
- Simultaneous requests: rotation guarantees each active requester is served within NUM_REQ packets. A requester that raises Req while another owns the lock waits in the queue.
- Req[g] dropping while in SEND/DRAIN has no effect; the byte is already captured.
- Busy high at reset exit: remain in LOAD until the transmitter reports idle. Never assert Send while Busy=1.
- Reset mid-byte:
  - Send drops immediately and Grant clears.
  - The transmitter finishes its current frame on its own.
  - No Ack is issued for a byte that was not captured.
- ReqLast on a single-byte packet: the lock is released after that byte.

Optional Feature:
- Macro: RS232_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in LOAD with Req[g]=0 and clears on any capture.
  - At TIMEOUT_CYCLES, clear Grant, pulse Abort, and go to ARB; rr_ptr stays on the stalled owner, so it has lowest priority next round.
- Without the macro: no counter is built, Abort is tied to 0, and a stalled owner holds the lock indefinitely.

Decomposition:
- Shared package rs232_pkg:
  - State encoding constants ARB/LOAD/SEND/DRAIN (2 bits).
  - Byte width constant 8.
- Sub-module rr_picker (combinational round-robin priority select: Req, rr_ptr -> one-hot winner, any).
  - This is the natural split.
  - It is reusable by other arbiters in the library.

Test Plan:
- Single request: Req[0]=1, ReqData=0x55, ReqLast=1, Busy model of 10-bit frame -> one Ack[0]; Send high until Busy rises; TxData=0x55; Grant returns to 0.
- Packet lock: requester 1 sends 0x01,0x02,0x03 (Last on 0x03) while Req[2] is held high -> all three bytes go out before Grant[2]; no interleaving.
- Round-robin: Req=4'b1111, one-byte packets -> grant order 0,1,2,3,0.
- Busy high at reset exit for 50 cycles with Req[3]=1 -> Send stays 0 until Busy=0; Ack[3] is issued on the Send-assert cycle.
- Reset asserted during SEND -> next cycle Send=0, Grant=0, Ack=0; after release, arbitration restarts at requester 0.
- RS232_TX_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=100: owner 2 sends a non-Last byte then drops Req -> Abort pulses at 100 stall cycles; a pending requester 3 is granted next.
